// File: rtl/bttn_debounce_pkg.sv
// Shared definitions for the push-button conditioning blocks.
// State encodings are fixed so other button blocks can decode them.
package bttn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LO = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_IDLE_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  // Registered output bundle: debounced level plus edge strobes.
  typedef struct packed {
    logic level;
    logic press;
    logic rels;
  } btn_out_t;

  localparam btn_out_t BTN_OUT_IDLE = '{level: 1'b0, press: 1'b0, rels: 1'b0};

endpackage

// File: rtl/bttn_sync.sv
// Shift-register synchroniser for an asynchronous pin, with synchronous
// active-low clear. Reusable for any single-bit input.
module bttn_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bttn_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/bttn_debounce.sv
// Push-button conditioner: polarity fix, synchroniser, 4-state debounce FSM
// with stability counter, registered level and one-cycle press/release strobes.
module bttn_debounce
  import bttn_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ACTIVE_LOW_IN   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic botonRaw,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("bttn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic           POL      = (ACTIVE_LOW_IN != 32'd0);

  logic             pin_c;
  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_out_t         out_q, out_d;

  // Normalise so that 1 always means pressed before synchronising.
  assign pin_c = botonRaw ^ POL;

  bttn_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pin_c),
    .q  (s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE_LO;
      cnt_q   <= '0;
      out_q   <= BTN_OUT_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Counter saturates at CNT_LAST: the FSM leaves WAIT_* on that sample.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_d         = out_q;
    out_d.press   = 1'b0;
    out_d.rels    = 1'b0;

    case (state_q)
      ST_IDLE_LO: begin
        if (s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      ST_WAIT_HI: begin
        if (!s) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE_HI;
          cnt_d       = '0;
          out_d.level = 1'b1;
          out_d.press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_IDLE_HI: begin
        if (!s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      ST_WAIT_LO: begin
        if (s) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE_LO;
          cnt_d       = '0;
          out_d.level = 1'b0;
          out_d.rels  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign btnLevel   = out_q.level;
  assign btnPress   = out_q.press;
  assign btnRelease = out_q.rels;

endmodule
